// File: rtl/pes_csum_pkg.sv
// Shared types and fold helper for the streaming RFC 1071 checksum engine.
// Build option PES_CSUM_VERIFY_EN (see pes_checksum_stream) does not affect this package.
package pes_csum_pkg;

  localparam int CSUM_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } csum_state_e;

  // Two end-around-carry passes cover any 32-bit input: the first leaves at most
  // 0x1FFFE, the second cannot carry again. An all-zero sum stays 0x0000.
  function automatic logic [CSUM_W-1:0] csum_fold(input logic [31:0] sum);
    logic [CSUM_W:0] s1;
    s1 = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
    return s1[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, s1[CSUM_W]};
  endfunction

endpackage

// File: rtl/pes_csum_lane_adder.sv
// Combinational lane adder: masks bytes by keep, sums all 16-bit lanes plus the
// running accumulator and returns the folded 16-bit ones-complement value.
module pes_csum_lane_adder
  import pes_csum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] keep_i,
  input  logic [CSUM_W-1:0]   acc_i,
  output logic [CSUM_W-1:0]   sum_o
);

  localparam int LANES = DATA_W / 16;
  localparam int BYTES = DATA_W / 8;

  logic [CSUM_W-1:0] lane_w [LANES];
  logic [31:0]       sum_full;

  // Lane 0 is the most-significant 16 bits, so it owns the two top byte enables.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int HB = BYTES - 1 - 2 * gi;
    localparam int LB = HB - 1;
    assign lane_w[gi] = {data_i[8*HB +: 8] & {8{keep_i[HB]}},
                         data_i[8*LB +: 8] & {8{keep_i[LB]}}};
  end

  // At most 17 lanes of 0xFFFF, so 32 bits of headroom never overflow.
  always_comb begin
    sum_full = {16'h0000, acc_i};
    for (int i = 0; i < LANES; i++) begin
      sum_full = sum_full + {16'h0000, lane_w[i]};
    end
    sum_o = csum_fold(sum_full);
  end

endmodule

// File: rtl/pes_checksum_stream.sv
// Streaming RFC 1071 checksum engine: accumulates beats, emits ~sum once per packet.
// Define PES_CSUM_VERIFY_EN to add out_ok (folded sum == 0xFFFF).
module pes_checksum_stream
  import pes_csum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CSUM_W-1:0]   out_checksum
`ifdef PES_CSUM_VERIFY_EN
  ,
  output logic                out_ok
`endif
);

  csum_state_e       state_q;
  logic [CSUM_W-1:0] acc_q;
  logic [CSUM_W-1:0] acc_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CSUM_W-1:0] out_checksum_q;
`ifdef PES_CSUM_VERIFY_EN
  logic              out_ok_q;
`endif

  pes_csum_lane_adder #(
    .DATA_W (DATA_W)
  ) u_lane_adder (
    .data_i (in_data),
    .keep_i (in_keep),
    .acc_i  (acc_q),
    .sum_o  (acc_d)
  );

  // in_ready_q is high exactly in ACCUM, so it doubles as the accept qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ACCUM;
      acc_q          <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_checksum_q <= '0;
`ifdef PES_CSUM_VERIFY_EN
      out_ok_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            if (in_last) begin
              out_checksum_q <= ~acc_d;
`ifdef PES_CSUM_VERIFY_EN
              out_ok_q       <= (acc_d == 16'hFFFF);
`endif
              acc_q          <= '0;
              state_q        <= HOLD;
              in_ready_q     <= 1'b0;
              out_valid_q    <= 1'b1;
            end else begin
              acc_q <= acc_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_checksum = out_checksum_q;
`ifdef PES_CSUM_VERIFY_EN
  assign out_ok       = out_ok_q;
`endif

endmodule

// File: tb/tb_pes_checksum_stream.sv
// Self-checking bench for pes_checksum_stream (DATA_W=32): vector table, corner
// sequences and randomized packets against a byte-weighted arithmetic model.
module tb_pes_checksum_stream;

  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_checksum;
`ifdef PES_CSUM_VERIFY_EN
  logic        out_ok;
`endif

  pes_checksum_stream #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_keep      (in_keep),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_checksum (out_checksum)
`ifdef PES_CSUM_VERIFY_EN
    ,
    .out_ok       (out_ok)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] pd[$];
  logic [3:0]  pk[$];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [15:0] exp_csum;
  } vec_t;

  vec_t vtab[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: weight every enabled byte by its position in network order,
  // add everything as plain integers, then reduce modulo 0xFFFF by end-around carry.
  function automatic logic [15:0] model_csum();
    longint s = 0;
    longint b_v;
    logic [15:0] r;
    foreach (pd[i]) begin
      for (int b = 0; b < 4; b++) begin
        if (pk[i][b]) begin
          b_v = longint'((pd[i] >> (8 * b)) & 32'hFF);
          s += (b % 2 == 1) ? b_v * 256 : b_v;
        end
      end
    end
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    r = s[15:0];
    return ~r;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last);
    int n = 0;
    logic rdy;
    in_data  = d;
    in_keep  = k;
    in_last  = last;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic send_pkt(input int gap);
    foreach (pd[i]) begin
      send_beat(pd[i], pk[i], i == pd.size() - 1);
      if (i != pd.size() - 1) begin
        check("mid_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Called #1 after the edge that accepted the last beat.
  task automatic collect(input string name, input logic [15:0] exp);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_csum"}, {16'b0, out_checksum}, {16'b0, exp});
`ifdef PES_CSUM_VERIFY_EN
    check({name, "_ok"}, {31'b0, out_ok}, {31'b0, exp == 16'h0000});
`endif
    $display("pkt %s beats=%0d csum=%h exp=%h", name, pd.size(), out_checksum, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_drop"}, {31'b0, out_valid}, 32'd0);
    check({name, "_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic load_hdr(input logic [15:0] csum_field);
    pd = '{32'h4500_0073, 32'h0000_4000, {16'h4011, csum_field}, 32'hC0A8_0001, 32'hC0A8_00C7};
    pk = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  endtask

  initial begin
    logic [15:0] exp;
    int len;
    int gap;

    vtab[0] = '{32'h4500_0073, 4'hF, 16'hBA8C};
    vtab[1] = '{32'hFFFF_0001, 4'hF, 16'hFFFE};
    vtab[2] = '{32'h0000_0000, 4'hF, 16'hFFFF};
    vtab[3] = '{32'hFFFF_FFFF, 4'hF, 16'h0000};
    vtab[4] = '{32'h1234_5678, 4'h0, 16'hFFFF};
    vtab[5] = '{32'hABCD_1234, 4'hC, 16'h5432};
    vtab[6] = '{32'h00FF_00FF, 4'h5, 16'hFE01};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_keep = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_csum", {16'b0, out_checksum}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vtab[i]) begin
      pd = '{vtab[i].data};
      pk = '{vtab[i].keep};
      send_pkt(0);
      collect($sformatf("vec%0d", i), vtab[i].exp_csum);
    end

    // Five-beat header with idle gaps, then the same header carrying its checksum.
    load_hdr(16'h0000);
    send_pkt(1);
    collect("hdr", 16'hB861);
    load_hdr(16'hB861);
    send_pkt(1);
    collect("hdr_verify", 16'h0000);

    // Partial keep on the last beat only.
    pd = '{32'h0000_0001, 32'hABCD_1234};
    pk = '{4'hF, 4'hC};
    send_pkt(0);
    collect("keep_last", 16'h5431);

    // Backpressure: beats offered during HOLD must be ignored.
    load_hdr(16'h0000);
    send_pkt(0);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_keep  = 4'hF;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_csum", {16'b0, out_checksum}, 32'h0000_B861);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("bp", 16'hB861);
    pd = '{32'h4500_0073};
    pk = '{4'hF};
    send_pkt(0);
    collect("after_bp", 16'hBA8C);

    // Reset while holding a result: output drops without waiting for a clock.
    send_pkt(0);
    rst = 1'b1;
    #1;
    check("rst_hold_valid", {31'b0, out_valid}, 32'd0);
    check("rst_hold_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-packet: partial sum is discarded.
    send_beat(32'h4500_0073, 4'hF, 1'b0);
    send_beat(32'h0000_4000, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    end
    load_hdr(16'h0000);
    send_pkt(0);
    collect("after_rst", 16'hB861);

    // Randomized packets against the model.
    for (int p = 0; p < 30; p++) begin
      pd.delete();
      pk.delete();
      len = $urandom_range(1, 6);
      gap = $urandom_range(0, 2);
      for (int b = 0; b < len; b++) begin
        pd.push_back($urandom);
        pk.push_back(4'($urandom_range(0, 15)));
      end
      exp = model_csum();
      send_pkt(gap);
      collect($sformatf("rnd%0d", p), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
